// File: rtl/audio_recorder.sv
// audio_recorder: captures one I2S ADC channel (16-bit, MSB first) and writes
// each sample to consecutive SRAM words starting at address 0. last_rec tells
// the playback stage how far the current take extends.
module audio_recorder #(
  parameter int unsigned       ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}},
  parameter bit                CHANNEL  = 1'b0
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  input  logic              aud_adclrck,
  input  logic              aud_adcdat,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq,
  output logic              sram_dq_oe,
  output logic              sram_we_n,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n,
  output logic [ADDR_W-1:0] last_rec,
  output logic              recording,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_LR, S_SHIFT, S_WRITE, S_PAUSE, S_END
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_sram_addr;
  logic [15:0]         r_sram_dq;
  logic                r_dq_oe;
  logic                r_we_n;
  logic [ADDR_W-1:0]   r_last_rec;
  logic [3:0]          r_bit_cnt;
  logic [15:0]         r_shreg;
  logic                r_lrc_d;
  logic                r_stop_pend;
  logic                r_pause_pend;

  logic                w_frame_start;
  logic [15:0]         w_shreg_nxt;
  logic                w_stop_any;
  logic                w_pause_any;
  logic                w_full;

  // A frame for our channel begins on the lrck transition into its half.
  assign w_frame_start = (r_lrc_d != aud_adclrck) && (aud_adclrck == CHANNEL);
  assign w_shreg_nxt   = {r_shreg[14:0], aud_adcdat};
  // Requests arriving during the write cycle itself still count for its exit.
  assign w_stop_any    = r_stop_pend  | stop;
  assign w_pause_any   = r_pause_pend | pause;
  assign w_full        = (r_addr == MAX_ADDR);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode; stop outranks pause, and both outrank a new frame so a
  // sample is never started only to be abandoned.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_nxt = S_WAIT_LR;
      S_WAIT_LR: begin
        if (stop)               w_state_nxt = S_END;
        else if (pause)         w_state_nxt = S_PAUSE;
        else if (w_frame_start) w_state_nxt = S_SHIFT;
      end
      S_SHIFT:   if (r_bit_cnt == 4'd15) w_state_nxt = S_WRITE;
      S_WRITE: begin
        if (w_full)           w_state_nxt = S_END;
        else if (w_stop_any)  w_state_nxt = S_END;
        else if (w_pause_any) w_state_nxt = S_PAUSE;
        else                  w_state_nxt = S_WAIT_LR;
      end
      S_PAUSE: begin
        if (stop)       w_state_nxt = S_END;
        else if (start) w_state_nxt = S_WAIT_LR;
      end
      S_END:     if (start) w_state_nxt = S_WAIT_LR;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Capture datapath: lrck history, shift register, address and take bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lrc_d      <= ~CHANNEL;
      r_shreg      <= '0;
      r_bit_cnt    <= '0;
      r_addr       <= '0;
      r_last_rec   <= '0;
      r_stop_pend  <= 1'b0;
      r_pause_pend <= 1'b0;
    end else begin
      r_lrc_d <= aud_adclrck;
      case (r_state)
        S_IDLE, S_END: begin
          // A fresh take always restarts at word 0.
          if (start) begin
            r_addr     <= '0;
            r_last_rec <= '0;
          end
        end
        S_WAIT_LR: r_bit_cnt <= '0;
        S_SHIFT: begin
          r_shreg   <= w_shreg_nxt;
          r_bit_cnt <= r_bit_cnt + 4'd1;
          if (stop)  r_stop_pend  <= 1'b1;
          if (pause) r_pause_pend <= 1'b1;
        end
        S_WRITE: begin
          r_last_rec   <= r_addr;
          if (!w_full) r_addr <= r_addr + ADDR_W'(1);
          r_stop_pend  <= 1'b0;
          r_pause_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // SRAM strobes are registered from the next state so they cover the whole
  // write cycle; the final data bit is folded in on the way into WRITE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sram_addr <= '0;
      r_sram_dq   <= '0;
      r_dq_oe     <= 1'b0;
      r_we_n      <= 1'b1;
    end else begin
      r_dq_oe <= (w_state_nxt == S_WRITE);
      r_we_n  <= (w_state_nxt != S_WRITE);
      if (w_state_nxt == S_WRITE) begin
        r_sram_addr <= r_addr;
        r_sram_dq   <= w_shreg_nxt;
      end
    end
  end

  assign sram_addr  = r_sram_addr;
  assign sram_dq    = r_sram_dq;
  assign sram_dq_oe = r_dq_oe;
  assign sram_we_n  = r_we_n;
  assign sram_ce_n  = 1'b0;
  assign sram_oe_n  = 1'b1;
  assign sram_ub_n  = 1'b0;
  assign sram_lb_n  = 1'b0;
  assign last_rec   = r_last_rec;
  assign recording  = (r_state == S_WAIT_LR) || (r_state == S_SHIFT) || (r_state == S_WRITE);
  assign done       = (r_state == S_END);

endmodule

// File: tb/tb_audio_recorder.sv
// tb_audio_recorder: three recorders share one I2S stream (default, MAX_ADDR=3,
// CHANNEL=1). Expected writes are queued when a frame is sent; a negedge
// monitor pops and compares whenever a recorder strobes we_n.
module tb_audio_recorder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst   = 3'b111;
  logic [2:0]  start = '0;
  logic [2:0]  pause = '0;
  logic [2:0]  stop  = '0;
  logic        lrck  = 1'b1;
  logic        adat  = 1'b0;

  logic [19:0] s_addr [3];
  logic [15:0] s_dq   [3];
  logic        dq_oe  [3];
  logic        we_n   [3];
  logic        ce_n   [3];
  logic        oe_n   [3];
  logic        ub_n   [3];
  logic        lb_n   [3];
  logic [19:0] lrec   [3];
  logic        rec    [3];
  logic        dn     [3];

  audio_recorder u0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .pause(pause[0]), .stop(stop[0]),
    .aud_adclrck(lrck), .aud_adcdat(adat),
    .sram_addr(s_addr[0]), .sram_dq(s_dq[0]), .sram_dq_oe(dq_oe[0]), .sram_we_n(we_n[0]),
    .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]), .sram_ub_n(ub_n[0]), .sram_lb_n(lb_n[0]),
    .last_rec(lrec[0]), .recording(rec[0]), .done(dn[0]));

  audio_recorder #(.MAX_ADDR(20'd3)) u1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .pause(pause[1]), .stop(stop[1]),
    .aud_adclrck(lrck), .aud_adcdat(adat),
    .sram_addr(s_addr[1]), .sram_dq(s_dq[1]), .sram_dq_oe(dq_oe[1]), .sram_we_n(we_n[1]),
    .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]), .sram_ub_n(ub_n[1]), .sram_lb_n(lb_n[1]),
    .last_rec(lrec[1]), .recording(rec[1]), .done(dn[1]));

  audio_recorder #(.CHANNEL(1'b1)) u2 (
    .clk(clk), .rst(rst[2]), .start(start[2]), .pause(pause[2]), .stop(stop[2]),
    .aud_adclrck(lrck), .aud_adcdat(adat),
    .sram_addr(s_addr[2]), .sram_dq(s_dq[2]), .sram_dq_oe(dq_oe[2]), .sram_we_n(we_n[2]),
    .sram_ce_n(ce_n[2]), .sram_oe_n(oe_n[2]), .sram_ub_n(ub_n[2]), .sram_lb_n(lb_n[2]),
    .last_rec(lrec[2]), .recording(rec[2]), .done(dn[2]));

  typedef struct {
    int          addr;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  logic [15:0] t5 [6] = '{16'h0F0F, 16'hF0F0, 16'h1357, 16'hFFFF, 16'h2468, 16'h0000};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int inst, input int addr, input logic [15:0] d, input int c);
    exp_t e;
    e.addr = addr; e.data = d; e.cyc = c;
    case (inst)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic mon(input int inst);
    exp_t e;
    int   n;
    n = (inst == 0) ? q0.size() : (inst == 1) ? q1.size() : q2.size();
    if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL u%0d_write: unexpected write addr %0h data %0h, none queued",
               inst, s_addr[inst], s_dq[inst]);
    end else begin
      case (inst)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      chk($sformatf("u%0d_wr_addr", inst), 32'(s_addr[inst]), 32'(e.addr));
      chk($sformatf("u%0d_wr_data", inst), 32'(s_dq[inst]),   32'(e.data));
      chk($sformatf("u%0d_wr_cyc",  inst), 32'(cyc),          32'(e.cyc));
      chk($sformatf("u%0d_wr_oe",   inst), 32'(dq_oe[inst]),  32'd1);
    end
  endtask

  // Monitor: every cycle with we_n low must match the next queued write.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++)
      if (we_n[i] === 1'b0) mon(i);
  end

  // One 64-bclk I2S frame; lrck and data change on falling bclk, MSB one
  // bclk after each lrck transition. aN < 0 means instance N must not write.
  task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                            input int a0, input int a1, input int a2);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (k == 0) begin
        lrck = 1'b0;
        if (a0 >= 0) push(0, a0, l, cyc + 17);
        if (a1 >= 0) push(1, a1, l, cyc + 17);
      end
      if (k == 32) begin
        lrck = 1'b1;
        if (a2 >= 0) push(2, a2, r, cyc + 17);
      end
      if (k >= 1 && k <= 16)       adat = l[16-k];
      else if (k >= 33 && k <= 48) adat = r[48-k];
      else                         adat = 1'b0;
    end
  endtask

  task automatic pulse_start(input int i);
    @(negedge clk); start[i] = 1'b1;
    @(negedge clk); start[i] = 1'b0;
  endtask

  task automatic do_reset(input int i);
    @(negedge clk); rst[i] = 1'b1;
    @(negedge clk); @(negedge clk); rst[i] = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_we_n%0d", i),  32'(we_n[i]),   32'd1);
      chk($sformatf("rst_oe%0d", i),    32'(dq_oe[i]),  32'd0);
      chk($sformatf("rst_lrec%0d", i),  32'(lrec[i]),   32'd0);
      chk($sformatf("rst_rec%0d", i),   32'(rec[i]),    32'd0);
      chk($sformatf("rst_done%0d", i),  32'(dn[i]),     32'd0);
      chk($sformatf("rst_addr%0d", i),  32'(s_addr[i]), 32'd0);
      chk($sformatf("rst_dq%0d", i),    32'(s_dq[i]),   32'd0);
    end
    chk("const_ce_n", 32'(ce_n[0]), 32'd0);
    chk("const_oe_n", 32'(oe_n[0]), 32'd1);
    chk("const_ub_n", 32'(ub_n[0]), 32'd0);
    chk("const_lb_n", 32'(lb_n[0]), 32'd0);
    rst = 3'b000;

    // Basic capture of three left words.
    pulse_start(0);
    chk("t1_rec", 32'(rec[0]), 32'd1);
    send_frame(16'hA5C3, 16'h0000, 0, -1, -1);
    send_frame(16'h0001, 16'h0000, 1, -1, -1);
    send_frame(16'h8000, 16'h0000, 2, -1, -1);
    chk("t1_lrec", 32'(lrec[0]), 32'd2);

    // Pause mid-sample: sample completes, then idles until resumed.
    do_reset(0);
    pulse_start(0);
    send_frame(16'h1111, 16'h0000, 0, -1, -1);
    fork
      send_frame(16'h2222, 16'h0000, 1, -1, -1);
      begin
        repeat (8) @(negedge clk);
        pause[0] = 1'b1;
        @(negedge clk);
        pause[0] = 1'b0;
      end
    join
    chk("t2_rec_paused", 32'(rec[0]),  32'd0);
    chk("t2_done",       32'(dn[0]),   32'd0);
    chk("t2_lrec",       32'(lrec[0]), 32'd1);
    send_frame(16'h3333, 16'h0000, -1, -1, -1);
    pulse_start(0);
    send_frame(16'h4444, 16'h0000, 2, -1, -1);
    chk("t2_lrec_resume", 32'(lrec[0]), 32'd2);

    // Stop and pause together in WAIT_LR after five writes.
    send_frame(16'h5555, 16'h0000, 3, -1, -1);
    send_frame(16'h6666, 16'h0000, 4, -1, -1);
    @(negedge clk); stop[0] = 1'b1; pause[0] = 1'b1;
    @(negedge clk); stop[0] = 1'b0; pause[0] = 1'b0;
    chk("t3_done", 32'(dn[0]),   32'd1);
    chk("t3_lrec", 32'(lrec[0]), 32'd4);
    chk("t3_rec",  32'(rec[0]),  32'd0);
    send_frame(16'h7777, 16'h0000, -1, -1, -1);
    pulse_start(0);
    send_frame(16'h8888, 16'h0000, 0, -1, -1);
    chk("t3_lrec_new", 32'(lrec[0]), 32'd0);

    // Reset landing on the write cycle.
    fork
      send_frame(16'h9999, 16'h0000, 1, -1, -1);
      begin
        int n;
        n = 0;
        while (we_n[0] !== 1'b0 && n < 40) begin
          @(negedge clk);
          n++;
        end
        chk("t4_write_seen", 32'(we_n[0]), 32'd0);
        rst[0] = 1'b1;
        @(negedge clk);
        chk("t4_we_n", 32'(we_n[0]),  32'd1);
        chk("t4_oe",   32'(dq_oe[0]), 32'd0);
        chk("t4_rec",  32'(rec[0]),   32'd0);
        chk("t4_done", 32'(dn[0]),    32'd0);
        chk("t4_lrec", 32'(lrec[0]),  32'd0);
        rst[0] = 1'b0;
      end
    join

    // Memory full at MAX_ADDR=3.
    pulse_start(1);
    for (int f = 0; f < 6; f++)
      send_frame(t5[f], 16'h0000, -1, (f < 4) ? f : -1, -1);
    chk("t5_done", 32'(dn[1]),   32'd1);
    chk("t5_lrec", 32'(lrec[1]), 32'd3);
    chk("t5_rec",  32'(rec[1]),  32'd0);

    // Right-channel capture.
    pulse_start(2);
    send_frame(16'h1111, 16'h2222, -1, -1, 0);
    send_frame(16'hAAAA, 16'h5555, -1, -1, 1);
    chk("t6_lrec", 32'(lrec[2]), 32'd1);

    repeat (5) @(negedge clk);
    chk("q0_empty", 32'(q0.size()), 32'd0);
    chk("q1_empty", 32'(q1.size()), 32'd0);
    chk("q2_empty", 32'(q2.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: cycle %0d reached, expected test end earlier", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/audio_recorder.md
Name: audio_recorder

Overview:
Upstream of the playback stage. Captures 16-bit mono samples from the codec ADC serial stream (I2S, clocked by aud_bclk), writes each sample to consecutive SRAM words from address 0, and reports the last written address as last_rec. The playback stage consumes last_rec to bound its reads. SRAM sharing with playback is arbitrated outside this block.

Parameters:
ADDR_W, 20, SRAM word-address width.
MAX_ADDR, 20'hFFFFF, last address written before auto-stop (memory full).
CHANNEL, 0, channel captured: 0 = left (adclrck low half), 1 = right (adclrck high half).

Ports:
clk  input  1  aud_bclk; all logic on rising edge.
rst  input  1  synchronous, active-high.
start  input  1  begin/resume recording; level, sampled each clk.
pause  input  1  pause request.
stop  input  1  stop request.
aud_adclrck  input  1  ADC left/right clock.
aud_adcdat  input  1  ADC serial data, MSB first.
sram_addr  output  ADDR_W  write address.
sram_dq  output  16  write data.
sram_dq_oe  output  1  1 = top level drives dq bus with sram_dq.
sram_we_n  output  1  write strobe, active low.
sram_ce_n  output  1  constant 0.
sram_oe_n  output  1  constant 1.
sram_ub_n  output  1  constant 0.
sram_lb_n  output  1  constant 0.
last_rec  output  ADDR_W  address of most recent written sample.
recording  output  1  1 in WAIT_LR, SHIFT, WRITE.
done  output  1  1 in END.

Behaviour:
- Reset values: state IDLE; addr_r 0; sram_addr 0; sram_dq 0; sram_dq_oe 0; sram_we_n 1; last_rec 0; recording 0; done 0; bit_cnt 0; lrc_d 1 if CHANNEL=0, else 0; stop/pause pending flags 0. Reset mid-write forces we_n=1 and dq_oe=0 at the same edge.
- Edge detect: lrc_d registers aud_adclrck each clk. Frame start = (lrc_d != lrc) and lrc == CHANNEL.
- States: IDLE, WAIT_LR, SHIFT, WRITE, PAUSE, END.
- IDLE: start -> WAIT_LR. addr_r := 0, last_rec := 0.
- WAIT_LR: on frame start -> SHIFT, bit_cnt := 0. That edge cycle is the I2S one-bit delay slot; no data is sampled in it.
  - stop -> END.
  - else pause -> PAUSE.
- SHIFT: each clk, shreg := {shreg[14:0], aud_adcdat}, bit_cnt++. After the 16th sample (bit_cnt == 15) -> WRITE. The first sampled bit is the MSB. Exactly 16 clks are spent in SHIFT.
- WRITE: exactly one cycle with sram_addr = addr_r, sram_dq = shreg, dq_oe = 1, we_n = 0. These outputs are registered and valid throughout the cycle. At exit:
  - last_rec := addr_r.
  - If addr_r == MAX_ADDR -> END.
  - Else addr_r++. Then stop_pend -> END; else pause_pend -> PAUSE; else WAIT_LR. Pending flags clear on exit.
  - Outside WRITE: we_n = 1 and dq_oe = 0.
- stop or pause asserted in SHIFT/WRITE sets a pending flag. The current sample still completes and is written. A partial sample is never written.
- Priority: stop beats pause. start is ignored in WAIT_LR, SHIFT and WRITE.
- PAUSE: start -> WAIT_LR with addr_r and last_rec preserved (resume). stop -> END.
- END: done = 1. start -> WAIT_LR with addr_r := 0 and last_rec := 0 (new take).
- Latency: the sample whose frame starts at edge E is written at E + 17 clks. At 48 kHz with 64 bclk/frame, 47 idle clks remain per frame.
- Wrap: addr_r never wraps. A memory-full condition ends in END with last_rec = MAX_ADDR.

Test Plan:
- Reset, start pulse, 3 I2S frames with left words 16'hA5C3, 16'h0001, 16'h8000 -> writes at addr 0,1,2 with those values; we_n low exactly one clk each, 17 clks after each falling lrck; last_rec = 2.
- Pause asserted mid-SHIFT of frame 2, later start -> frame 2 still written at addr 1; PAUSE entered; resume writes the next frame at addr 2; no address skipped.
- stop and pause asserted together in WAIT_LR after 5 writes -> END; done = 1; last_rec = 4; later start -> next write at addr 0.
- MAX_ADDR = 3, 6 frames -> writes at addr 0..3 only; END after the addr-3 write; last_rec = 3; no further we_n pulses.
- rst asserted during WRITE cycle -> next edge we_n = 1, dq_oe = 0, state IDLE, last_rec = 0.
- CHANNEL = 1, left 16'h1111, right 16'h2222 -> only 16'h2222 written.
